spi_slave: RTL and testbench

//  SPI target (slave) for the far end of the team's SPI master link: same SPI_MODE map, byte-wide UI.

---
 rtl/spi_slave.sv | 173 +++++++++++++++++
 tb/tb_spi_slave.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI target: oversamples SCLK/CS_n/MOSI in the clk domain, shifts MSB-first,
// and offers byte-wide RX strobes plus a one-entry TX staging register.
module spi_slave #(
    parameter int SPI_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_TX_Underrun,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_OE
);

    localparam logic CPOL = (SPI_MODE >= 2) ? 1'b1 : 1'b0;
    localparam logic CPHA = (SPI_MODE == 1 || SPI_MODE == 3) ? 1'b1 : 1'b0;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_prev, cs_prev;
    logic       sclk_s, cs_s, mosi_s;
    logic       leading_edge, trailing_edge, sample_edge, shift_edge, cs_fall;

    logic [7:0] stage_byte;
    logic       stage_full;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [2:0] bit_cnt;

    logic       load, load_first, sample_en, shift_en, abort;
    logic       capture, underrun_now;
    logic [7:0] load_byte;

    // Synchronisers idle at the bus rest levels so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= CPOL;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign leading_edge  = (sclk_prev == CPOL) && (sclk_s != CPOL);
    assign trailing_edge = (sclk_prev != CPOL) && (sclk_s == CPOL);
    assign sample_edge   = CPHA ? trailing_edge : leading_edge;
    assign shift_edge    = CPHA ? leading_edge : trailing_edge;
    assign cs_fall       = cs_prev && !cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_first = 1'b0;
        sample_en  = 1'b0;
        shift_en   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    load       = 1'b1;
                    load_first = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    sample_en = sample_edge;
                    shift_en  = shift_edge;
                    load      = sample_edge && (bit_cnt == 3'd7);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A byte offered in the very cycle of a load goes straight to the shifter.
    assign capture      = i_TX_DV && !stage_full;
    assign load_byte    = stage_full ? stage_byte : (capture ? i_TX_Byte : 8'h00);
    assign underrun_now = load && !stage_full && !capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_full <= 1'b0;
            stage_byte <= 8'h00;
        end else if (load) begin
            stage_full <= 1'b0;
        end else if (capture) begin
            stage_full <= 1'b1;
            stage_byte <= i_TX_Byte;
        end
    end

    // tx_shift holds bits not yet driven; CPHA=0 drives bit7 at CS fall itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift   <= 8'h00;
            o_SPI_MISO <= 1'b0;
        end else if (abort) begin
            tx_shift   <= 8'h00;
            o_SPI_MISO <= 1'b0;
        end else if (load) begin
            if (!CPHA && load_first) begin
                o_SPI_MISO <= load_byte[7];
                tx_shift   <= {load_byte[6:0], 1'b0};
            end else begin
                tx_shift <= load_byte;
            end
        end else if (shift_en) begin
            o_SPI_MISO <= tx_shift[7];
            tx_shift   <= {tx_shift[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift      <= 8'h00;
            bit_cnt       <= 3'd0;
            o_RX_DV       <= 1'b0;
            o_RX_Byte     <= 8'h00;
            o_TX_Underrun <= 1'b0;
        end else begin
            o_RX_DV       <= 1'b0;
            o_TX_Underrun <= underrun_now;
            if (abort) begin
                rx_shift <= 8'h00;
                bit_cnt  <= 3'd0;
            end else if (sample_en) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    o_RX_DV   <= 1'b1;
                    o_RX_Byte <= {rx_shift[6:0], mosi_s};
                end
            end
        end
    end

    assign o_TX_Ready    = !stage_full;
    assign o_SPI_MISO_OE = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench: one spi_slave per SPI mode, a bit-banged master,
// and a scoreboard of expected RX bytes checked whenever o_RX_DV fires.
module tb_spi_slave;

    localparam int HP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sclk, cs_n, mosi, tx_dv;
    logic [3:0] miso, oe, tx_ready, rx_dv, underrun;
    logic [7:0] tx_byte [4];
    logic [7:0] rx_byte [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g), .SYNC_STAGES(2)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_TX_Byte    (tx_byte[g]),
            .i_TX_DV      (tx_dv[g]),
            .o_TX_Ready   (tx_ready[g]),
            .o_RX_DV      (rx_dv[g]),
            .o_RX_Byte    (rx_byte[g]),
            .o_TX_Underrun(underrun[g]),
            .i_SPI_Clk    (sclk[g]),
            .i_SPI_CS_n   (cs_n[g]),
            .i_SPI_MOSI   (mosi[g]),
            .o_SPI_MISO   (miso[g]),
            .o_SPI_MISO_OE(oe[g])
        );
    end

    typedef struct {
        int         mode;
        bit         stage_en;
        logic [7:0] stage;
        logic [7:0] mosi_byte;
        logic [7:0] exp_miso;
        int         exp_underruns;
    } vec_t;

    typedef struct {
        int         mode;
        logic [7:0] data;
    } rx_exp_t;

    vec_t    vecs [6];
    rx_exp_t sb_q [$];
    int      n_checks = 0;
    int      n_fail = 0;
    int      underrun_cnt [4];
    logic [3:0] prev_dv;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_rx(input int m, input logic [7:0] b);
        rx_exp_t e;
        e.mode = m;
        e.data = b;
        sb_q.push_back(e);
    endtask

    // Runs forever alongside the stimulus; pops the scoreboard on every RX strobe.
    task automatic monitor_rx();
        rx_exp_t e;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                if (underrun[m]) underrun_cnt[m]++;
                if (rx_dv[m]) begin
                    checkOutput($sformatf("rx_dv back-to-back m%0d", m), {31'b0, prev_dv[m]}, 32'd0);
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected rx_dv m%0d: got byte 0x%0h, expected no strobe", m, rx_byte[m]);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("rx mode", m, e.mode);
                        checkOutput($sformatf("rx byte m%0d", m), {24'b0, rx_byte[m]}, {24'b0, e.data});
                    end
                end
            end
            prev_dv = rx_dv;
        end
    endtask

    task automatic stage_byte(input int m, input logic [7:0] b);
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        @(negedge clk);
        tx_dv[m]   = 1'b0;
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        wait_clk(HP);
    endtask

    task automatic cs_high(input int m);
        wait_clk(HP);
        cs_n[m] = 1'b1;
        wait_clk(2 * HP);
    endtask

    task automatic xfer_bits(input int m, input logic [7:0] dout, input int nbits, output logic [7:0] din);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = (m == 1 || m == 3);
        din  = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[m] = dout[7-i];
                wait_clk(HP);
                din     = {din[6:0], miso[m]};
                sclk[m] = ~cpol;
                wait_clk(HP);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = dout[7-i];
                wait_clk(HP);
                din     = {din[6:0], miso[m]};
                sclk[m] = cpol;
                wait_clk(HP);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int         m;
        int         u0;
        logic [7:0] got;
        m  = v.mode;
        u0 = underrun_cnt[m];
        if (v.stage_en) begin
            stage_byte(m, v.stage);
            checkOutput($sformatf("ready after stage m%0d", m), {31'b0, tx_ready[m]}, 32'd0);
            stage_byte(m, ~v.stage);
        end
        push_rx(m, v.mosi_byte);
        cs_low(m);
        checkOutput($sformatf("oe active m%0d", m), {31'b0, oe[m]}, 32'd1);
        checkOutput($sformatf("ready after load m%0d", m), {31'b0, tx_ready[m]}, 32'd1);
        xfer_bits(m, v.mosi_byte, 8, got);
        cs_high(m);
        checkOutput($sformatf("miso byte m%0d", m), {24'b0, got}, {24'b0, v.exp_miso});
        checkOutput($sformatf("oe idle m%0d", m), {31'b0, oe[m]}, 32'd0);
        checkOutput($sformatf("miso idle m%0d", m), {31'b0, miso[m]}, 32'd0);
        checkOutput($sformatf("underrun count m%0d", m), underrun_cnt[m] - u0, v.exp_underruns);
    endtask

    task automatic check_reset_values(input int m);
        checkOutput($sformatf("reset ready m%0d", m), {31'b0, tx_ready[m]}, 32'd1);
        checkOutput($sformatf("reset rx_dv m%0d", m), {31'b0, rx_dv[m]}, 32'd0);
        checkOutput($sformatf("reset rx_byte m%0d", m), {24'b0, rx_byte[m]}, 32'd0);
        checkOutput($sformatf("reset underrun m%0d", m), {31'b0, underrun[m]}, 32'd0);
        checkOutput($sformatf("reset miso m%0d", m), {31'b0, miso[m]}, 32'd0);
        checkOutput($sformatf("reset oe m%0d", m), {31'b0, oe[m]}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] got1, got2;
        vec_t       v;
        int         u0;

        vecs[0] = '{0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
        vecs[1] = '{1, 1'b1, 8'h81, 8'h7E, 8'h81, 1};
        vecs[2] = '{2, 1'b1, 8'h81, 8'h7E, 8'h81, 1};
        vecs[3] = '{3, 1'b1, 8'h81, 8'h7E, 8'h81, 1};
        vecs[4] = '{3, 1'b0, 8'h00, 8'hC3, 8'h00, 2};
        vecs[5] = '{2, 1'b1, 8'hFF, 8'h5A, 8'hFF, 1};

        rst_n   = 1'b0;
        prev_dv = 4'b0;
        for (int m = 0; m < 4; m++) begin
            sclk[m]         = (m >= 2);
            cs_n[m]         = 1'b1;
            mosi[m]         = 1'b0;
            tx_dv[m]        = 1'b0;
            tx_byte[m]      = 8'h00;
            underrun_cnt[m] = 0;
        end
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        for (int m = 0; m < 4; m++) check_reset_values(m);

        fork
            monitor_rx();
        join_none

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Two bytes under one CS, restaging once the first byte has been loaded.
        for (int k = 0; k < 2; k++) begin
            int m;
            m  = (k == 0) ? 0 : 3;
            u0 = underrun_cnt[m];
            stage_byte(m, 8'h11);
            push_rx(m, 8'h5A);
            push_rx(m, 8'hC3);
            cs_low(m);
            checkOutput($sformatf("b2b ready m%0d", m), {31'b0, tx_ready[m]}, 32'd1);
            stage_byte(m, 8'h22);
            xfer_bits(m, 8'h5A, 8, got1);
            xfer_bits(m, 8'hC3, 8, got2);
            cs_high(m);
            checkOutput($sformatf("b2b first miso m%0d", m), {24'b0, got1}, 32'h11);
            checkOutput($sformatf("b2b second miso m%0d", m), {24'b0, got2}, 32'h22);
            checkOutput($sformatf("b2b underruns m%0d", m), underrun_cnt[m] - u0, 32'd1);
        end

        // Underrun at CS fall with nothing staged.
        u0 = underrun_cnt[0];
        push_rx(0, 8'hA7);
        cs_low(0);
        checkOutput("underrun pulse at cs fall", underrun_cnt[0] - u0, 32'd1);
        checkOutput("underrun ready", {31'b0, tx_ready[0]}, 32'd1);
        xfer_bits(0, 8'hA7, 8, got1);
        cs_high(0);
        checkOutput("underrun miso byte", {24'b0, got1}, 32'h00);
        checkOutput("underrun ready after", {31'b0, tx_ready[0]}, 32'd1);

        // CS abort after five bits, then a clean byte must still frame correctly.
        stage_byte(0, 8'hF0);
        cs_low(0);
        xfer_bits(0, 8'hFF, 5, got1);
        cs_high(0);
        checkOutput("abort oe", {31'b0, oe[0]}, 32'd0);
        checkOutput("abort miso", {31'b0, miso[0]}, 32'd0);
        checkOutput("abort ready", {31'b0, tx_ready[0]}, 32'd1);
        v = '{0, 1'b1, 8'h69, 8'h96, 8'h69, 1};
        applyStimulus(v);

        // Reset mid-transfer after three bits.
        stage_byte(2, 8'h55);
        cs_low(2);
        xfer_bits(2, 8'hE0, 3, got1);
        rst_n = 1'b0;
        wait_clk(2);
        cs_n[2] = 1'b1;
        sclk[2] = 1'b1;
        mosi[2] = 1'b0;
        check_reset_values(2);
        rst_n = 1'b1;
        wait_clk(4);
        checkOutput("post-reset ready", {31'b0, tx_ready[2]}, 32'd1);
        checkOutput("post-reset rx_byte", {24'b0, rx_byte[2]}, 32'd0);
        v = '{2, 1'b1, 8'hC7, 8'h38, 8'hC7, 1};
        applyStimulus(v);

        wait_clk(20);
        checkOutput("scoreboard drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
